// File: rtl/despertadorcpu_btn_pkg.sv
// Shared types and default timing constants for the alarm-off button debouncer.
package despertadorcpu_btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM_PRESS,
        ST_PRESSED,
        ST_CONFIRM_RELEASE
    } btn_state_t;

    // 10 ms debounce and 2 s long-press at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_LONG_CYCLES     = 100000000;
    localparam bit          DEF_BTN_ACTIVE_LOW  = 1'b1;

endpackage

// File: rtl/despertadorcpu_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is parameterised.
module despertadorcpu_sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/despertadorcpu_btn_debounce.sv
// Push-button debouncer: synchronized level, press/release strobes and a one-shot long-press strobe.
module despertadorcpu_btn_debounce
    import despertadorcpu_btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LW = $clog2(LONG_CYCLES);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYCLES - 2);

    logic btn_sync;
    logic s;

    btn_state_t    state, state_n;
    logic [DW-1:0] db_cnt, db_cnt_n;
    logic [LW-1:0] long_cnt, long_cnt_n;
    logic          long_done, long_done_n;
    logic          btn_level_n, press_n, release_n, long_n;

    // Reset the synchronizer to the released pin level so deassertion looks idle
    despertadorcpu_sync2 #(
        .RESET_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    assign s = btn_sync ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            db_cnt        <= '0;
            long_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            db_cnt        <= db_cnt_n;
            long_cnt      <= long_cnt_n;
            long_done     <= long_done_n;
            btn_level     <= btn_level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
        end
    end

    always_comb begin
        state_n     = state;
        db_cnt_n    = db_cnt;
        long_cnt_n  = long_cnt;
        long_done_n = long_done;
        btn_level_n = btn_level;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_n  = ST_CONFIRM_PRESS;
                    db_cnt_n = '0;
                end
            end

            ST_CONFIRM_PRESS: begin
                if (!s) begin
                    state_n = ST_IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_n     = ST_PRESSED;
                    btn_level_n = 1'b1;
                    press_n     = 1'b1;
                    long_cnt_n  = '0;
                    long_done_n = 1'b0;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end

            ST_PRESSED: begin
                if (long_cnt != LONG_LAST) begin
                    long_cnt_n = long_cnt + 1'b1;
                end
                // Strobe on the edge that brings the counter to LONG_CYCLES-1
                if ((long_cnt == LONG_PRE) && !long_done) begin
                    long_n      = 1'b1;
                    long_done_n = 1'b1;
                end
                if (!s) begin
                    state_n  = ST_CONFIRM_RELEASE;
                    db_cnt_n = '0;
                end
            end

            ST_CONFIRM_RELEASE: begin
                if (s) begin
                    state_n = ST_PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_n     = ST_IDLE;
                    btn_level_n = 1'b0;
                    release_n   = 1'b1;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_despertadorcpu_btn_debounce.sv
// Directed bench for the button debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pin.
module tb_despertadorcpu_btn_debounce;

    logic clk;
    logic reset;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int checks   = 0;
    int failures = 0;
    int long_seen;

    despertadorcpu_btn_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lvl, input logic pp,
                           input logic rp, input logic lp);
        chk({tag, ".btn_level"},     btn_level,     lvl);
        chk({tag, ".press_pulse"},   press_pulse,   pp);
        chk({tag, ".release_pulse"}, release_pulse, rp);
        chk({tag, ".long_pulse"},    long_pulse,    lp);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b1;
        #1;
        chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk_all("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all($sformatf("post_reset_idle[%0d]", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Clean press; first step is the first edge sampling the low pin
        btn_raw   = 1'b0;
        long_seen = 0;
        for (int k = 0; k <= 45; k++) begin
            step();
            chk_all($sformatf("press_hold[%0d]", k), (k >= 6), (k == 6), 1'b0, (k == 25));
            if (long_pulse === 1'b1) long_seen++;
        end
        checks++;
        assert (long_seen == 1)
        else begin
            failures++;
            $error("FAIL long_pulse_count observed=%0d expected=1", long_seen);
        end

        // Bouncy release: high 2, low 3, then high
        btn_raw = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            chk_all($sformatf("bouncy_release[%0d]", k), (k < 11), 1'b0, (k == 11), 1'b0);
            if (k == 1) btn_raw = 1'b0;
            if (k == 4) btn_raw = 1'b1;
        end

        // Glitch: low for 3 sampling edges only
        btn_raw = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            step();
            chk_all($sformatf("glitch[%0d]", k), 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 2) btn_raw = 1'b1;
        end

        // Reset mid-press
        btn_raw = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            step();
            chk_all($sformatf("press2[%0d]", k), (k >= 6), (k == 6), 1'b0, 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        chk_all("reset_mid_press_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("reset_mid_press_held", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            step();
            chk_all($sformatf("repress_after_reset[%0d]", k), (k >= 6), (k == 6), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/despertadorcpu_btn_debounce.md
DESPERTADORCPU_BTN_DEBOUNCE -- requirements
Module: despertadorcpu_btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable cycles needed to accept a level change (10 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter LONG_CYCLES, default 100000000: cycles in PRESSED before long_pulse (2 s at 50 MHz); must exceed DEBOUNCE_CYCLES.
REQ-003 SHALL have parameter BTN_ACTIVE_LOW, default 1: 1 = btn_raw low means pressed.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 btn_raw  input  1  raw asynchronous push-button pin.
REQ-007 btn_level  output  1  debounced level, 1 = pressed; drives the PIO in_port of the alarm-off button.
REQ-008 press_pulse  output  1  one-cycle strobe when a press is accepted.
REQ-009 release_pulse  output  1  one-cycle strobe when a release is accepted.
REQ-010 long_pulse  output  1  one-cycle strobe, at most once per press, after LONG_CYCLES held.

Function
REQ-011 SHALL pass btn_raw through a 2-flop synchronizer, then XOR with BTN_ACTIVE_LOW to form s (1 = pressed).
REQ-012 SHALL implement FSM states IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-013 IDLE: s=1 -> CONFIRM_PRESS, debounce counter cleared to 0.
REQ-014 CONFIRM_PRESS: s=0 -> IDLE (glitch rejected, no output change); s=1 with cnt<DEBOUNCE_CYCLES-1 -> cnt+1; s=1 with cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-015 Entering PRESSED SHALL set btn_level=1, assert press_pulse for exactly one cycle, clear long counter and long-done flag.
REQ-016 PRESSED: long counter increments each cycle, saturating; on reaching LONG_CYCLES-1 with long-done clear, assert long_pulse one cycle and set long-done; s=0 -> CONFIRM_RELEASE, debounce counter cleared.
REQ-017 CONFIRM_RELEASE: s=1 -> PRESSED without press_pulse, long counter and long-done retained (frozen during CONFIRM_RELEASE); s=0 with cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level=0, release_pulse one cycle; otherwise cnt+1.
REQ-018 Latency: with btn_raw stable, btn_level changes on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge sampling the new btn_raw value.
REQ-019 Pulses SHALL be registered, mutually exclusive in any cycle, and never asserted while a prior pulse of the same kind is high.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter; no wrap-around permitted (saturate).

Reset
REQ-021 Reset SHALL asynchronously force state IDLE, btn_level=0, all pulses 0, all counters 0, long-done 0.
REQ-022 Synchronizer flops SHALL reset to the released pin level (1 if BTN_ACTIVE_LOW) so deassertion produces no spurious press.
REQ-023 Reset asserted mid-press SHALL drop btn_level immediately with no release_pulse; after deassertion a still-held button re-debounces as a new press.

Structure
REQ-024 Package despertadorcpu_btn_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-025 Synchronizer SHALL be a sub-module despertadorcpu_sync2 (2 flops, parameterised reset value).

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_LOW=1)
REQ-026 Clean press: btn_raw 1->0 held -> btn_level rises on edge 6 after first sampling edge, press_pulse high exactly that cycle.
REQ-027 Glitch: btn_raw low for 3 cycles then high -> btn_level stays 0, no pulses.
REQ-028 Long hold: btn_raw low 40 cycles -> exactly one long_pulse, 19 cycles after press_pulse; none afterwards.
REQ-029 Bouncy release: during PRESSED btn_raw high 2 cycles, low again, then high 10 cycles -> no release on bounce; single release_pulse and btn_level=0 after 4 stable high samples.
REQ-030 Reset mid-press: assert reset while btn_level=1 -> btn_level=0 same cycle asynchronously, no release_pulse; held button after reset -> new press_pulse after 6 edges.
